// File: rtl/cdb_pkg.sv
// Shared defaults and source identifiers for the common data bus arbiter.
package cdb_pkg;

  localparam int DEF_N_SRC  = 3;
  localparam int DEF_TAG_W  = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 2;

  // Fixed producer slots on the bus; the index doubles as the FIFO number.
  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_LSB = 2'd1,
    SRC_BR  = 2'd2
  } src_id_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-to-arbiter request bundle plus the registered broadcast slot.
interface cdb_arbiter_if import cdb_pkg::*; #(
  parameter int N_SRC  = DEF_N_SRC,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int DATA_W = DEF_DATA_W
);

  localparam int SRC_W = $clog2(N_SRC);

  logic [N_SRC-1:0]        req_valid;
  logic [N_SRC*TAG_W-1:0]  req_tag;
  logic [N_SRC*DATA_W-1:0] req_value;
  logic [N_SRC-1:0]        req_ready;
  logic                    out_valid;
  logic [TAG_W-1:0]        out_tag;
  logic [DATA_W-1:0]       out_value;
  logic [SRC_W-1:0]        out_src;

  // Producers and bus consumers.
  modport master (
    output req_valid, req_tag, req_value,
    input  req_ready, out_valid, out_tag, out_value, out_src
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_tag, req_value,
    output req_ready, out_valid, out_tag, out_value, out_src
  );

endinterface

// File: rtl/cdb_src_fifo.sv
// Small per-producer result FIFO with a synchronous clear and a global enable.
// Callers never push when full nor pop when empty; count is exported so the
// caller can derive both conditions from registered state.
module cdb_src_fifo import cdb_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_TAG_W + DEF_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointer and occupancy bookkeeping; clear wins over any same-cycle push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        unique case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage array; contents beyond the pointers are don't-care so no reset.
  always_ff @(posedge clk) begin
    if (en && !clear && push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one FIFO per result producer, a round-robin pick
// of the first non-empty FIFO starting at rr_ptr, and a registered broadcast
// slot. A pushed entry is never visible to the scheduler on the same edge.
module cdb_arbiter import cdb_pkg::*; #(
  parameter int N_SRC  = DEF_N_SRC,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);

  localparam int SRC_W = $clog2(N_SRC);
  localparam int ENT_W = TAG_W + DATA_W;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [CNT_W-1:0]  fifo_count [N_SRC];
  logic [ENT_W-1:0]  fifo_head  [N_SRC];
  logic [SRC_W-1:0]  scan_idx   [N_SRC];
  logic [N_SRC-1:0]  fifo_ready;
  logic [N_SRC-1:0]  not_empty;
  logic [N_SRC-1:0]  push;
  logic [N_SRC-1:0]  pop;

  logic [SRC_W-1:0]  rr_ptr;
  logic [SRC_W-1:0]  win_idx;
  logic [SRC_W-1:0]  next_ptr;
  logic              win_found;
  logic [ENT_W-1:0]  win_entry;

  logic              out_valid_q;
  logic [TAG_W-1:0]  out_tag_q;
  logic [DATA_W-1:0] out_value_q;
  logic [SRC_W-1:0]  out_src_q;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    // Ready comes from the registered count only, so a full FIFO that is
    // popped this cycle still refuses the push.
    assign fifo_ready[i] = (fifo_count[i] != CNT_W'(DEPTH));
    assign not_empty[i]  = (fifo_count[i] != '0);
    assign push[i]       = bus.req_valid[i] & fifo_ready[i];
    assign pop[i]        = win_found & (win_idx == SRC_W'(i));
    assign scan_idx[i]   = SRC_W'((int'(rr_ptr) + i) % N_SRC);

    cdb_src_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .en    (rdy),
      .clear (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   ({bus.req_tag[i*TAG_W +: TAG_W], bus.req_value[i*DATA_W +: DATA_W]}),
      .count (fifo_count[i]),
      .head  (fifo_head[i])
    );
  end

  // Round-robin pick: scan from the far end so the slot nearest rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = N_SRC-1; k >= 0; k--) begin
      if (not_empty[scan_idx[k]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[k];
      end
    end
  end

  assign win_entry = fifo_head[win_idx];
  assign next_ptr  = (win_idx == SRC_W'(N_SRC-1)) ? '0 : win_idx + SRC_W'(1);

  // Broadcast slot and round-robin pointer; rdy low freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_value_q <= '0;
      out_src_q   <= '0;
      rr_ptr      <= '0;
    end else if (rdy) begin
      if (flush) begin
        out_valid_q <= 1'b0;
        rr_ptr      <= '0;
      end else if (win_found) begin
        out_valid_q <= 1'b1;
        out_tag_q   <= win_entry[ENT_W-1 -: TAG_W];
        out_value_q <= win_entry[DATA_W-1:0];
        out_src_q   <= win_idx;
        rr_ptr      <= next_ptr;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready = fifo_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_value = out_value_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N  = 3;
  localparam int TW = 4;
  localparam int DW = 32;
  localparam int DP = 2;

  logic clk;
  logic rst;
  logic rdy;
  logic flush;

  cdb_arbiter_if #(.N_SRC(N), .TAG_W(TW), .DATA_W(DW)) bus();

  cdb_arbiter #(.N_SRC(N), .TAG_W(TW), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Reference state: one queue of {tag,value} per producer and the expected slot.
  logic [TW+DW-1:0] mq [N][$];
  logic             exp_valid = 1'b0;
  logic [TW-1:0]    exp_tag   = '0;
  logic [DW-1:0]    exp_value = '0;
  int               exp_src   = 0;
  int               mrr       = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] make_val(int s, logic [3:0] t);
    return 32'hC0DE_0000 + 32'(s * 256) + {28'd0, t};
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] req);
    total_cnt++;
    if (act !== req) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    exp_valid = 1'b0;
    exp_tag   = '0;
    exp_value = '0;
    exp_src   = 0;
    mrr       = 0;
  endtask

  // One clock edge of the arbiter's rules: pop the round-robin winner from
  // the pre-edge queues, then append accepted pushes.
  task automatic model_step();
    bit               can_push [N];
    bit               found;
    int               w;
    logic [TW+DW-1:0] e;
    if (!rdy) return;
    if (flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      exp_valid = 1'b0;
      mrr       = 0;
      return;
    end
    for (int i = 0; i < N; i++) can_push[i] = (mq[i].size() != DP);
    found = 1'b0;
    w     = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && mq[(mrr + k) % N].size() > 0) begin
        found = 1'b1;
        w     = (mrr + k) % N;
      end
    end
    if (found) begin
      e         = mq[w].pop_front();
      exp_valid = 1'b1;
      exp_tag   = e[TW+DW-1:DW];
      exp_value = e[DW-1:0];
      exp_src   = w;
      mrr       = (w + 1) % N;
    end else begin
      exp_valid = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] && can_push[i])
        mq[i].push_back({bus.req_tag[i*TW +: TW], bus.req_value[i*DW +: DW]});
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Every negative edge out of reset, all outputs must match the model.
  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    if (!rst) begin
      for (int i = 0; i < N; i++) exp_ready[i] = (mq[i].size() != DP);
      checkOutput("model req_ready", 64'(bus.req_ready), 64'(exp_ready));
      checkOutput("model out_valid", 64'(bus.out_valid), 64'(exp_valid));
      checkOutput("model out_tag",   64'(bus.out_tag),   64'(exp_tag));
      checkOutput("model out_value", 64'(bus.out_value), 64'(exp_value));
      checkOutput("model out_src",   64'(bus.out_src),   64'(exp_src));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] v, input logic [3:0] t0, input logic [3:0] t1,
                               input logic [3:0] t2, input logic r, input logic f);
    bus.req_valid = v;
    bus.req_tag   = {t2, t1, t0};
    bus.req_value = {make_val(2, t2), make_val(1, t1), make_val(0, t0)};
    rdy           = r;
    flush         = f;
    tick();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) applyStimulus(3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic checkSlot(string name, logic v, logic [3:0] t, logic [31:0] val, int s);
    checkOutput({name, " valid"}, 64'(bus.out_valid), 64'(v));
    if (v) begin
      checkOutput({name, " tag"},   64'(bus.out_tag),   64'(t));
      checkOutput({name, " value"}, 64'(bus.out_value), 64'(val));
      checkOutput({name, " src"},   64'(bus.out_src),   64'(s));
    end
  endtask

  initial begin
    rst           = 1'b1;
    rdy           = 1'b0;
    flush         = 1'b0;
    bus.req_valid = '0;
    bus.req_tag   = '0;
    bus.req_value = '0;
    tick();
    tick();
    checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset out_tag",   64'(bus.out_tag),   64'd0);
    checkOutput("reset out_value", 64'(bus.out_value), 64'd0);
    checkOutput("reset out_src",   64'(bus.out_src),   64'd0);
    checkOutput("reset req_ready", 64'(bus.req_ready), 64'b111);
    rst = 1'b0;
    tick();

    // Single ALU result: one-cycle pulse one edge after the push.
    bus.req_valid = 3'b001;
    bus.req_tag   = {4'd0, 4'd0, 4'd3};
    bus.req_value = {32'd0, 32'd0, 32'h0000_1234};
    rdy           = 1'b1;
    flush         = 1'b0;
    tick();
    checkSlot("t1 push edge", 1'b0, 4'd0, 32'd0, 0);
    idle(1);
    checkSlot("t1 bcast", 1'b1, 4'd3, 32'h0000_1234, SRC_ALU);
    idle(1);
    checkSlot("t1 after", 1'b0, 4'd0, 32'd0, 0);

    // All three push together from rr_ptr=0: served in source order.
    applyStimulus(3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    applyStimulus(3'b111, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0);
    idle(1);
    checkSlot("t2 first", 1'b1, 4'd1, 32'hC0DE_0001, SRC_ALU);
    idle(1);
    checkSlot("t2 second", 1'b1, 4'd2, 32'hC0DE_0102, SRC_LSB);
    idle(1);
    checkSlot("t2 third", 1'b1, 4'd3, 32'hC0DE_0203, SRC_BR);
    applyStimulus(3'b101, 4'd5, 4'd0, 4'd6, 1'b1, 1'b0);
    checkSlot("t2 gap", 1'b0, 4'd0, 32'd0, 0);
    idle(1);
    checkSlot("t2 rr wrapped", 1'b1, 4'd5, 32'hC0DE_0005, SRC_ALU);
    idle(1);
    checkSlot("t2 rr next", 1'b1, 4'd6, 32'hC0DE_0206, SRC_BR);
    idle(1);

    // Stalled pushes, then the LSB FIFO fills while others are served.
    applyStimulus(3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    applyStimulus(3'b010, 4'd0, 4'd7, 4'd0, 1'b0, 1'b0);
    applyStimulus(3'b010, 4'd0, 4'd7, 4'd0, 1'b0, 1'b0);
    checkOutput("t3 stall ready", 64'(bus.req_ready), 64'b111);
    checkOutput("t3 stall valid", 64'(bus.out_valid), 64'd0);
    applyStimulus(3'b111, 4'd8, 4'd4, 4'd9, 1'b1, 1'b0);
    applyStimulus(3'b011, 4'd10, 4'd5, 4'd0, 1'b1, 1'b0);
    checkOutput("t3 full ready", 64'(bus.req_ready), 64'b101);
    checkSlot("t3 alu", 1'b1, 4'd8, 32'hC0DE_0008, SRC_ALU);
    applyStimulus(3'b010, 4'd0, 4'd6, 4'd0, 1'b1, 1'b0);
    checkSlot("t3 lsb first", 1'b1, 4'd4, 32'hC0DE_0104, SRC_LSB);
    checkOutput("t3 ready back", 64'(bus.req_ready), 64'b111);
    applyStimulus(3'b010, 4'd0, 4'd6, 4'd0, 1'b1, 1'b0);
    checkSlot("t3 br", 1'b1, 4'd9, 32'hC0DE_0209, SRC_BR);
    idle(1);
    checkSlot("t3 alu second", 1'b1, 4'd10, 32'hC0DE_000A, SRC_ALU);
    idle(1);
    checkSlot("t3 lsb second", 1'b1, 4'd5, 32'hC0DE_0105, SRC_LSB);
    idle(1);
    checkSlot("t3 lsb third", 1'b1, 4'd6, 32'hC0DE_0106, SRC_LSB);
    idle(1);
    checkSlot("t3 drained", 1'b0, 4'd0, 32'd0, 0);

    // Flush with two ALU entries and one branch entry pending.
    applyStimulus(3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    applyStimulus(3'b011, 4'd1, 4'd2, 4'd0, 1'b1, 1'b0);
    applyStimulus(3'b101, 4'd3, 4'd0, 4'd4, 1'b1, 1'b0);
    applyStimulus(3'b001, 4'd5, 4'd0, 4'd0, 1'b1, 1'b0);
    checkOutput("t4 pre ready", 64'(bus.req_ready), 64'b110);
    applyStimulus(3'b010, 4'd0, 4'd9, 4'd0, 1'b1, 1'b1);
    checkOutput("t4 flush valid", 64'(bus.out_valid), 64'd0);
    checkOutput("t4 flush ready", 64'(bus.req_ready), 64'b111);
    checkOutput("t4 flush tag hold", 64'(bus.out_tag), 64'd2);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      checkOutput("t4 no stale", 64'(bus.out_valid), 64'd0);
    end

    // rdy low for three cycles in the middle of a burst.
    applyStimulus(3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    applyStimulus(3'b111, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0);
    idle(1);
    checkSlot("t5 before", 1'b1, 4'd1, 32'hC0DE_0001, SRC_ALU);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b111, 4'd7, 4'd7, 4'd7, 1'b0, 1'b1);
      checkSlot("t5 frozen", 1'b1, 4'd1, 32'hC0DE_0001, SRC_ALU);
      checkOutput("t5 frozen ready", 64'(bus.req_ready), 64'b111);
    end
    idle(1);
    checkSlot("t5 resume lsb", 1'b1, 4'd2, 32'hC0DE_0102, SRC_LSB);
    idle(1);
    checkSlot("t5 resume br", 1'b1, 4'd3, 32'hC0DE_0203, SRC_BR);
    idle(1);
    checkSlot("t5 done", 1'b0, 4'd0, 32'd0, 0);

    // Asynchronous reset between edges while entries are pending.
    applyStimulus(3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    applyStimulus(3'b011, 4'd1, 4'd2, 4'd0, 1'b1, 1'b0);
    idle(1);
    checkSlot("t6 before", 1'b1, 4'd1, 32'hC0DE_0001, SRC_ALU);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6 async valid", 64'(bus.out_valid), 64'd0);
    checkOutput("t6 async tag",   64'(bus.out_tag),   64'd0);
    checkOutput("t6 async ready", 64'(bus.req_ready), 64'b111);
    tick();
    rst = 1'b0;
    idle(2);
    checkSlot("t6 discarded", 1'b0, 4'd0, 32'd0, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
